// File: rtl/isa16_step_ctrl.sv
// isa16_step_ctrl: turns the board step/mode keys into a one-cycle CPU clock
// enable on the free-running system clock. It supports single-step, free-run
// at a fixed rate, and a PC breakpoint. It also counts issued enables.
module isa16_step_ctrl #(
  parameter int PC_W            = 10,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RUN_DIV         = 5000000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             key_step_n,
  input  logic             key_mode_n,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc,
  output logic             cpu_en,
  output logic             mode_run,
  output logic             bp_hit,
  output logic [CNT_W-1:0] step_count
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RATE_W = $clog2(RUN_DIV);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [RATE_W-1:0] RATE_LAST = RATE_W'(RUN_DIV - 1);
  localparam int KEY_STEP = 0;
  localparam int KEY_MODE = 1;

  typedef enum logic [1:0] {
    ST_STEP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BREAK = 2'd2
  } state_t;

  // Key path registers; bit 0 is the step key and bit 1 is the mode key.
  logic [1:0]      key_raw_s;
  logic [1:0]      sync1_r;
  logic [1:0]      sync2_r;
  logic [1:0]      deb_r;
  logic [1:0]      deb_d_r;
  logic [1:0]      press_r;
  logic [DB_W-1:0] db_cnt_r [2];

  // Execution control state
  state_t            state_r;
  logic [RATE_W-1:0] rate_cnt_r;
  logic              armed_r;
  logic              cpu_en_r;
  logic              mode_run_r;
  logic              bp_hit_r;
  logic [CNT_W-1:0]  step_count_r;

  logic step_ev_s;
  logic mode_ev_s;
  logic bp_trap_s;

  assign key_raw_s = {key_mode_n, key_step_n};
  assign step_ev_s = press_r[KEY_STEP];
  assign mode_ev_s = press_r[KEY_MODE];
  // The CPU updates pc one cycle after each pulse, so by the time the rate
  // counter wraps again the compare sees the settled address.
  assign bp_trap_s = bp_en & armed_r & (pc == bp_addr);

  // Synchronise and debounce both keys, then emit one pulse per accepted press
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_r <= 2'b11;
      sync2_r <= 2'b11;
      deb_r   <= 2'b11;
      deb_d_r <= 2'b11;
      press_r <= 2'b00;
      for (int k = 0; k < 2; k++) begin
        db_cnt_r[k] <= {DB_W{1'b0}};
      end
    end else begin
      sync1_r <= key_raw_s;
      sync2_r <= sync1_r;
      deb_d_r <= deb_r;
      // Only a debounced 1->0 transition counts as a press.
      press_r <= deb_d_r & ~deb_r;
      for (int k = 0; k < 2; k++) begin
        if (db_cnt_r[k] == DB_LAST) begin
          // The level differed for the full window, so accept it.
          deb_r[k]    <= ~deb_r[k];
          db_cnt_r[k] <= {DB_W{1'b0}};
        end else if (sync2_r[k] != deb_r[k]) begin
          db_cnt_r[k] <= db_cnt_r[k] + DB_W'(1);
        end else begin
          db_cnt_r[k] <= {DB_W{1'b0}};
        end
      end
    end
  end

  // Mode FSM, rate divider, breakpoint arming and the registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r      <= ST_STEP;
      rate_cnt_r   <= {RATE_W{1'b0}};
      armed_r      <= 1'b1;
      cpu_en_r     <= 1'b0;
      mode_run_r   <= 1'b0;
      bp_hit_r     <= 1'b0;
      step_count_r <= {CNT_W{1'b0}};
    end else begin
      cpu_en_r <= 1'b0;
      // The count advances on the same edge that the CPU consumes the enable.
      if (cpu_en_r) begin
        step_count_r <= step_count_r + CNT_W'(1);
      end
      case (state_r)
        ST_STEP: begin
          // When both keys fire together, the mode key wins.
          if (mode_ev_s) begin
            state_r    <= ST_RUN;
            rate_cnt_r <= {RATE_W{1'b0}};
            mode_run_r <= 1'b1;
            bp_hit_r   <= 1'b0;
          end else if (step_ev_s) begin
            cpu_en_r <= 1'b1;
            armed_r  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (mode_ev_s) begin
            state_r    <= ST_STEP;
            rate_cnt_r <= {RATE_W{1'b0}};
            mode_run_r <= 1'b0;
          end else if (rate_cnt_r == RATE_LAST) begin
            rate_cnt_r <= {RATE_W{1'b0}};
            if (bp_trap_s) begin
              // Disarm so that resuming executes the breakpoint instruction once.
              state_r    <= ST_BREAK;
              armed_r    <= 1'b0;
              mode_run_r <= 1'b0;
              bp_hit_r   <= 1'b1;
            end else begin
              cpu_en_r <= 1'b1;
              armed_r  <= 1'b1;
            end
          end else begin
            rate_cnt_r <= rate_cnt_r + RATE_W'(1);
          end
        end
        ST_BREAK: begin
          if (mode_ev_s) begin
            state_r    <= ST_RUN;
            rate_cnt_r <= {RATE_W{1'b0}};
            mode_run_r <= 1'b1;
            bp_hit_r   <= 1'b0;
          end else if (step_ev_s) begin
            state_r  <= ST_STEP;
            cpu_en_r <= 1'b1;
            armed_r  <= 1'b1;
            bp_hit_r <= 1'b0;
          end
        end
        default: begin
          state_r    <= ST_STEP;
          rate_cnt_r <= {RATE_W{1'b0}};
          mode_run_r <= 1'b0;
          bp_hit_r   <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_en     = cpu_en_r;
  assign mode_run   = mode_run_r;
  assign bp_hit     = bp_hit_r;
  assign step_count = step_count_r;

endmodule

// File: tb/tb_isa16_step_ctrl.sv
// Bench for isa16_step_ctrl. Expected cpu_en pulse cycles are pushed to a
// scoreboard queue when keys are driven. Each observed pulse must match the
// head of that queue. A second, small instance covers the step_count wrap.
module tb_isa16_step_ctrl;
  localparam int PC_W = 10;
  localparam int DB   = 4;
  localparam int RD   = 8;
  localparam int CW   = 16;
  // Latency from driving a key (between edges) to the resulting registered action
  localparam int KEY_LAT = DB + 5;

  logic            clk = 1'b0;
  logic            resetn;
  logic            key_step_n;
  logic            key_mode_n;
  logic            bp_en;
  logic [PC_W-1:0] bp_addr;
  logic [PC_W-1:0] pc;
  logic            cpu_en;
  logic            mode_run;
  logic            bp_hit;
  logic [CW-1:0]   step_count;

  logic            w_key_mode_n;
  logic            w_key_step_n;
  logic            w_bp_en;
  logic [PC_W-1:0] w_zero;
  logic            w_cpu_en;
  logic            w_mode_run;
  logic            w_bp_hit;
  logic [3:0]      w_step_count;

  int cyc;
  int checks;
  int errors;
  int exp_cnt;
  int exp_q[$];
  logic prev_en;

  typedef struct {
    int low_len;
    int high_len;
    bit exp_pulse;
  } press_vec_t;
  press_vec_t vecs[6];

  always #5 clk = ~clk;

  isa16_step_ctrl #(.PC_W(PC_W), .DEBOUNCE_CYCLES(DB), .RUN_DIV(RD), .CNT_W(CW)) dut (
    .clk(clk), .resetn(resetn), .key_step_n(key_step_n), .key_mode_n(key_mode_n),
    .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .cpu_en(cpu_en),
    .mode_run(mode_run), .bp_hit(bp_hit), .step_count(step_count)
  );

  isa16_step_ctrl #(.PC_W(PC_W), .DEBOUNCE_CYCLES(1), .RUN_DIV(2), .CNT_W(4)) u_wrap (
    .clk(clk), .resetn(resetn), .key_step_n(w_key_step_n), .key_mode_n(w_key_mode_n),
    .bp_en(w_bp_en), .bp_addr(w_zero), .pc(w_zero), .cpu_en(w_cpu_en),
    .mode_run(w_mode_run), .bp_hit(w_bp_hit), .step_count(w_step_count)
  );

  // CPU model: the PC advances on each edge that samples cpu_en high
  always @(posedge clk or negedge resetn) begin
    if (!resetn) pc <= '0;
    else if (cpu_en) pc <= pc + 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance to the next falling edge and score cpu_en against the queue.
  task automatic tick();
    @(negedge clk);
    cyc++;
    while (exp_q.size() > 0 && exp_q[0] < cyc) begin
      checks++;
      errors++;
      $display("FAIL pulse_missing: actual=none required=pulse at cycle %0d (now %0d)", exp_q[0], cyc);
      void'(exp_q.pop_front());
    end
    if (cpu_en) begin
      checks++;
      if (exp_q.size() > 0 && exp_q[0] == cyc) begin
        void'(exp_q.pop_front());
      end else begin
        errors++;
        $display("FAIL pulse_unexpected: actual=1 required=0 at cycle %0d", cyc);
      end
      if (prev_en) begin
        checks++;
        errors++;
        $display("FAIL pulse_back_to_back: actual=1 required=0 at cycle %0d", cyc);
      end
    end
    prev_en = cpu_en;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Push the RUN pulses for a mode change registered at cycle s, up to but excluding stop.
  task automatic push_run(input int s, input int stop);
    for (int t = s + RD; t < stop; t += RD) exp_q.push_back(t);
  endtask

  initial begin
    int m;
    int s;
    resetn = 1'b0; key_step_n = 1'b1; key_mode_n = 1'b1; bp_en = 1'b0; bp_addr = '0;
    w_key_mode_n = 1'b1; w_key_step_n = 1'b1; w_bp_en = 1'b0; w_zero = '0;
    cyc = 0; checks = 0; errors = 0; exp_cnt = 0; prev_en = 1'b0;

    vecs[0] = '{20, 14, 1'b1};  // clean press held 20 cycles
    vecs[1] = '{2, 12, 1'b0};   // short glitch
    vecs[2] = '{3, 12, 1'b0};   // glitch one cycle shorter than the window
    vecs[3] = '{4, 14, 1'b1};   // exactly the debounce window
    vecs[4] = '{10, 12, 1'b1};
    vecs[5] = '{1, 12, 1'b0};

    tick_n(3);
    check("reset_cpu_en", 32'(cpu_en), 32'd0);
    check("reset_mode_run", 32'(mode_run), 32'd0);
    check("reset_bp_hit", 32'(bp_hit), 32'd0);
    check("reset_step_count", 32'(step_count), 32'd0);
    resetn = 1'b1;
    tick_n(2);

    // Counter wrap on the small instance: D=1, RUN_DIV=2, 4-bit count.
    m = cyc;
    w_key_mode_n = 1'b0;
    s = m + 1 + 5;
    while (cyc < s + 31) tick();
    check("wrap_mode_run", 32'(w_mode_run), 32'd1);
    check("wrap_all_ones", 32'(w_step_count), 32'hF);
    tick_n(2);
    check("wrap_to_zero", 32'(w_step_count), 32'h0);
    w_key_mode_n = 1'b1;

    // Table of step presses in STEP mode.
    for (int i = 0; i < 6; i++) begin
      m = cyc;
      key_step_n = 1'b0;
      if (vecs[i].exp_pulse) begin
        exp_q.push_back(m + KEY_LAT);
        exp_cnt++;
      end
      tick_n(vecs[i].low_len);
      key_step_n = 1'b1;
      tick_n(vecs[i].high_len);
      check("step_vec_count", 32'(step_count), 32'(exp_cnt));
      check("step_vec_mode_run", 32'(mode_run), 32'd0);
    end

    // Bounce at 3-cycle intervals, then hold low.
    for (int i = 0; i < 5; i++) begin
      key_step_n = 1'b0; tick_n(3);
      key_step_n = 1'b1; tick_n(3);
    end
    check("bounce_no_pulse", 32'(step_count), 32'(exp_cnt));
    m = cyc;
    key_step_n = 1'b0;
    exp_q.push_back(m + KEY_LAT);
    exp_cnt++;
    tick_n(20);
    key_step_n = 1'b1;
    tick_n(12);
    check("bounce_then_press", 32'(step_count), 32'(exp_cnt));

    // RUN for five pulses; a step press in RUN is ignored; mode press stops.
    m = cyc;
    s = m + KEY_LAT;
    key_mode_n = 1'b0;
    push_run(s, s + 41);
    tick_n(20);
    key_mode_n = 1'b1;
    check("run_mode_run", 32'(mode_run), 32'd1);
    tick_n(5);
    key_step_n = 1'b0;
    tick_n(15);
    key_step_n = 1'b1;
    while (cyc < s + 32) tick();
    key_mode_n = 1'b0;
    tick_n(12);
    key_mode_n = 1'b1;
    exp_cnt += 5;
    check("run_five_pulses", 32'(step_count), 32'(exp_cnt));
    check("run_stopped_mode", 32'(mode_run), 32'd0);
    tick_n(24);
    check("run_stays_stopped", 32'(step_count), 32'(exp_cnt));

    // Fresh reset, then run into the breakpoint at 0x005.
    resetn = 1'b0;
    tick();
    check("reset2_step_count", 32'(step_count), 32'd0);
    resetn = 1'b1;
    tick_n(2);
    bp_en = 1'b1;
    bp_addr = 10'h005;
    m = cyc;
    s = m + KEY_LAT;
    key_mode_n = 1'b0;
    push_run(s, s + 41);
    tick_n(20);
    key_mode_n = 1'b1;
    while (cyc < s + 50) tick();
    check("bp_hit", 32'(bp_hit), 32'd1);
    check("bp_mode_run", 32'(mode_run), 32'd0);
    check("bp_step_count", 32'(step_count), 32'd5);
    check("bp_pc", 32'(pc), 32'h005);
    tick_n(20);
    check("bp_holds", 32'(step_count), 32'd5);

    // Resume: the breakpoint instruction runs once, then trap again at 0x008.
    bp_addr = 10'h008;
    m = cyc;
    s = m + KEY_LAT;
    key_mode_n = 1'b0;
    push_run(s, s + 25);
    while (cyc < s + 9) tick();
    check("resume_pc", 32'(pc), 32'h006);
    check("resume_mode_run", 32'(mode_run), 32'd1);
    check("resume_bp_hit", 32'(bp_hit), 32'd0);
    key_mode_n = 1'b1;
    while (cyc < s + 34) tick();
    check("bp2_hit", 32'(bp_hit), 32'd1);
    check("bp2_pc", 32'(pc), 32'h008);
    check("bp2_step_count", 32'(step_count), 32'd8);

    // Step out of BREAK.
    m = cyc;
    key_step_n = 1'b0;
    exp_q.push_back(m + KEY_LAT);
    tick_n(15);
    key_step_n = 1'b1;
    tick_n(10);
    check("brk_step_bp_hit", 32'(bp_hit), 32'd0);
    check("brk_step_mode_run", 32'(mode_run), 32'd0);
    check("brk_step_count", 32'(step_count), 32'd9);
    check("brk_step_pc", 32'(pc), 32'h009);

    // Simultaneous step and mode presses in STEP: RUN wins, no step pulse.
    m = cyc;
    s = m + KEY_LAT;
    key_step_n = 1'b0;
    key_mode_n = 1'b0;
    push_run(s, s + 25);
    tick_n(15);
    key_step_n = 1'b1;
    key_mode_n = 1'b1;
    while (cyc < s + 24) tick();
    check("both_mode_run", 32'(mode_run), 32'd1);
    check("both_step_count", 32'(step_count), 32'd11);
    check("mid_pulse_high", 32'(cpu_en), 32'd1);

    // Asynchronous reset in the middle of a pulse.
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst_cpu_en", 32'(cpu_en), 32'd0);
    check("async_rst_mode_run", 32'(mode_run), 32'd0);
    check("async_rst_bp_hit", 32'(bp_hit), 32'd0);
    check("async_rst_step_count", 32'(step_count), 32'd0);
    tick_n(2);
    resetn = 1'b1;
    tick_n(20);
    check("post_rst_mode_run", 32'(mode_run), 32'd0);
    m = cyc;
    key_step_n = 1'b0;
    exp_q.push_back(m + KEY_LAT);
    tick_n(15);
    key_step_n = 1'b1;
    tick_n(10);
    check("post_rst_step", 32'(step_count), 32'd1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
